// File: rtl/flag_pkg.sv
// Shared definitions for the flag stack unit: NZCV bit positions, the ARM
// condition-code encoding and the B.cond evaluation function.
package flag_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // NV is "always" on ARMv8, so it shares the AL result.
    function automatic logic cond_eval(input cond_e c, input logic [3:0] nzcv);
        logic n_s;
        logic z_s;
        logic c_s;
        logic v_s;
        logic res_s;
        n_s = nzcv[FLAG_N];
        z_s = nzcv[FLAG_Z];
        c_s = nzcv[FLAG_C];
        v_s = nzcv[FLAG_V];
        case (c)
            COND_EQ: res_s = z_s;
            COND_NE: res_s = ~z_s;
            COND_CS: res_s = c_s;
            COND_CC: res_s = ~c_s;
            COND_MI: res_s = n_s;
            COND_PL: res_s = ~n_s;
            COND_VS: res_s = v_s;
            COND_VC: res_s = ~v_s;
            COND_HI: res_s = c_s & ~z_s;
            COND_LS: res_s = ~c_s | z_s;
            COND_GE: res_s = (n_s == v_s);
            COND_LT: res_s = (n_s != v_s);
            COND_GT: res_s = ~z_s & (n_s == v_s);
            COND_LE: res_s = z_s | (n_s != v_s);
            COND_AL: res_s = 1'b1;
            COND_NV: res_s = 1'b1;
            default: res_s = 1'b1;
        endcase
        return res_s;
    endfunction

endpackage

// File: rtl/flag_lifo.sv
// STACK_DEPTH x NUM_FLAGS save/restore stack. Resolves the effective push/pop
// for the cycle, tracks depth and presents the current top entry.
module flag_lifo #(
    parameter int NUM_FLAGS   = 4,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [NUM_FLAGS-1:0] wr_data,
    output logic                 push_eff,
    output logic                 pop_eff,
    output logic [NUM_FLAGS-1:0] top_data,
    output logic [DEPTH_W-1:0]   depth,
    output logic                 full,
    output logic                 empty
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [NUM_FLAGS-1:0] stack_q [STACK_DEPTH];
    logic [NUM_FLAGS-1:0] stack_d [STACK_DEPTH];
    logic [DEPTH_W-1:0]   depth_q;
    logic [DEPTH_W-1:0]   depth_d;
    logic                 full_s;
    logic                 empty_s;
    logic [IDX_W-1:0]     wr_idx_s;
    logic [IDX_W-1:0]     rd_idx_s;

    // Occupancy status and effective operations; simultaneous push+pop cancel.
    always_comb begin
        full_s   = (depth_q == DEPTH_W'(STACK_DEPTH));
        empty_s  = (depth_q == {DEPTH_W{1'b0}});
        push_eff = push & ~pop & ~full_s;
        pop_eff  = pop & ~push & ~empty_s;
        wr_idx_s = IDX_W'(depth_q);
        if (empty_s) begin
            rd_idx_s = {IDX_W{1'b0}};
        end else begin
            rd_idx_s = IDX_W'(depth_q - DEPTH_W'(1));
        end
    end

    // Next stack contents and depth; popped entries keep their stale data.
    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        if (push_eff) begin
            stack_d[wr_idx_s] = wr_data;
            depth_d           = depth_q + DEPTH_W'(1);
        end else if (pop_eff) begin
            depth_d = depth_q - DEPTH_W'(1);
        end else begin
            depth_d = depth_q;
        end
    end

    // Stack storage and depth register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= {NUM_FLAGS{1'b0}};
            end
            depth_q <= {DEPTH_W{1'b0}};
        end else begin
            stack_q <= stack_d;
            depth_q <= depth_d;
        end
    end

    // Output drive from registered state.
    always_comb begin
        top_data = stack_q[rd_idx_s];
        depth    = depth_q;
        full     = full_s;
        empty    = empty_s;
    end

endmodule

// File: rtl/flag_stack_unit.sv
// Masked condition-flag register with forwarding, B.cond evaluation and a
// save/restore stack for exception entry and return.
module flag_stack_unit
    import flag_pkg::*;
#(
    parameter int NUM_FLAGS   = 4,
    parameter int STACK_DEPTH = 4,
    parameter int FWD_EN      = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_FLAGS-1:0]               flags_in,
    input  logic                               set_flag,
    input  logic [NUM_FLAGS-1:0]               set_mask,
    input  logic                               push,
    input  logic                               pop,
    input  logic [3:0]                         cond,
    input  logic                               err_clear,
    output logic [NUM_FLAGS-1:0]               flags_out,
    output logic [NUM_FLAGS-1:0]               flags_fwd,
    output logic                               cond_true,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               err_overflow,
    output logic                               err_underflow
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [NUM_FLAGS-1:0] flags_q;
    logic [NUM_FLAGS-1:0] flags_d;
    logic                 err_overflow_q;
    logic                 err_overflow_d;
    logic                 err_underflow_q;
    logic                 err_underflow_d;
    logic [NUM_FLAGS-1:0] base_s;
    logic [NUM_FLAGS-1:0] top_data_s;
    logic                 push_eff_s;
    logic                 pop_eff_s;
    logic                 full_s;
    logic                 empty_s;
    logic [DEPTH_W-1:0]   depth_s;

    // Stack always saves the pre-update registered flags.
    flag_lifo #(
        .NUM_FLAGS   (NUM_FLAGS),
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_lifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (push),
        .pop      (pop),
        .wr_data  (flags_q),
        .push_eff (push_eff_s),
        .pop_eff  (pop_eff_s),
        .top_data (top_data_s),
        .depth    (depth_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    // Next flags: a masked set overrides a restored value bit by bit.
    always_comb begin
        if (pop_eff_s) begin
            base_s = top_data_s;
        end else begin
            base_s = flags_q;
        end
        if (set_flag) begin
            flags_d = (flags_in & set_mask) | (base_s & ~set_mask);
        end else begin
            flags_d = base_s;
        end
    end

    // Sticky error bits; clear wins over a same-cycle new error.
    always_comb begin
        if (err_clear) begin
            err_overflow_d  = 1'b0;
            err_underflow_d = 1'b0;
        end else begin
            err_overflow_d  = err_overflow_q  | (push & ~pop & full_s);
            err_underflow_d = err_underflow_q | (pop & ~push & empty_s);
        end
    end

    // Flag and error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q         <= {NUM_FLAGS{1'b0}};
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            flags_q         <= flags_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Forwarding path and condition evaluation; generic flags are ignored.
    always_comb begin
        if (FWD_EN != 0) begin
            flags_fwd = flags_d;
        end else begin
            flags_fwd = flags_q;
        end
        cond_true = cond_eval(cond_e'(cond), flags_fwd[3:0]);
    end

    // Output drive.
    always_comb begin
        flags_out     = flags_q;
        depth         = depth_s;
        stack_full    = full_s;
        stack_empty   = empty_s;
        err_overflow  = err_overflow_q;
        err_underflow = err_underflow_q;
    end

endmodule
